// File: rtl/if_id_skid_reg_if.sv
// Instruction-stage handshake bundle: valid/ready plus PC, PC+4 and instruction word.
// The master drives valid and the payload, and the slave drives ready.
interface if_id_skid_reg_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pcplus4;
  logic [31:0]     instr;

  modport master (output valid, pc, pcplus4, instr, input  ready);
  modport slave  (input  valid, pc, pcplus4, instr, output ready);
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register with a one-entry skid buffer and a synchronous flush.
// Define IFID_PERF_EN to add the perf_fetched, perf_stall and perf_flushed counters.
module if_id_skid_reg #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rstn,
  if_id_skid_reg_if.slave          fetch,
  if_id_skid_reg_if.master         dec,
  input  logic                     flush
`ifdef IFID_PERF_EN
  ,
  output logic [XLEN-1:0]          perf_fetched,
  output logic [XLEN-1:0]          perf_stall,
  output logic [XLEN-1:0]          perf_flushed
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [31:0]     instr;
  } ent_t;

  ent_t main_q, sk_q, in_ent;
  logic id_valid, sk_valid;
  logic in_fire, out_fire;

  assign in_ent   = '{pc: fetch.pc, pcplus4: fetch.pcplus4, instr: fetch.instr};
  assign in_fire  = fetch.valid & ~sk_valid;
  assign out_fire = id_valid & dec.ready;

  assign fetch.ready = ~sk_valid;
  assign dec.valid   = id_valid;
  assign dec.pc      = main_q.pc;
  assign dec.pcplus4 = main_q.pcplus4;
  assign dec.instr   = main_q.instr;

  // main_q.instr is forced to NOP whenever id_valid drops, so id_instr stays flop-driven.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_valid <= 1'b0;
      sk_valid <= 1'b0;
      main_q   <= '{pc: '0, pcplus4: '0, instr: NOP_INSTR};
      sk_q     <= '{pc: '0, pcplus4: '0, instr: NOP_INSTR};
    end else if (flush) begin
      id_valid     <= 1'b0;
      sk_valid     <= 1'b0;
      main_q.instr <= NOP_INSTR;
    end else if (sk_valid) begin
      if (out_fire) begin
        main_q   <= sk_q;
        sk_valid <= 1'b0;
      end
    end else if (id_valid) begin
      if (in_fire && out_fire) begin
        main_q <= in_ent;
      end else if (in_fire) begin
        sk_q     <= in_ent;
        sk_valid <= 1'b1;
      end else if (out_fire) begin
        id_valid     <= 1'b0;
        main_q.instr <= NOP_INSTR;
      end
    end else if (in_fire) begin
      main_q   <= in_ent;
      id_valid <= 1'b1;
    end
  end

`ifdef IFID_PERF_EN
  logic [1:0] flush_cnt;

  assign flush_cnt = {1'b0, id_valid & ~out_fire} + {1'b0, sk_valid} + {1'b0, in_fire};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flushed <= '0;
    end else begin
      if (in_fire)               perf_fetched <= perf_fetched + 1'b1;
      if (id_valid && !dec.ready) perf_stall  <= perf_stall + 1'b1;
      if (flush)                 perf_flushed <= perf_flushed + XLEN'(flush_cnt);
    end
  end
`endif

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- IF/ID pipeline boundary register. Sits directly downstream of the instruction-fetch stage.
- Captures the fetched PC, PC+4 and instruction, and presents them to the decode stage.
- Uses a valid/ready handshake. A one-entry skid buffer keeps the fetch-side ready signal registered-clean, so a decode stall never drops an instruction.
- Supports a synchronous flush for branch/jump redirects. Decode sees a NOP whenever no valid instruction is held.

Parameters:
- XLEN, 32: width of the PC, PC+4 and instruction fields.
- NOP_INSTR, 32'h0000_0013: value driven on id_instr when id_valid=0 (addi x0,x0,0).

Ports:
- clk, in, 1: pipeline clock; all state updates on rising edge.
- rstn, in, 1: asynchronous active-low reset.
- if_valid, in, 1: fetch stage offers an instruction this cycle.
- if_ready, out, 1: block can accept; equals ~skid_valid.
- if_pc, in, XLEN: PC of the offered instruction.
- if_pcplus4, in, XLEN: PC+4 of the offered instruction.
- if_instr, in, 32: offered instruction word.
- flush, in, 1: discard all held and incoming instructions this cycle.
- id_valid, out, 1: decode-side output holds a valid instruction.
- id_ready, in, 1: decode stage consumes the output this cycle.
- id_pc, out, XLEN: PC of the presented instruction.
- id_pcplus4, out, XLEN: PC+4 of the presented instruction.
- id_instr, out, 32: presented instruction; NOP_INSTR when id_valid=0.

Behaviour:
- Clocking and reset: one clock, clk. rstn is asynchronous, active-low. While rstn=0: id_valid=0, id_pc=0, id_pcplus4=0, id_instr=NOP_INSTR, skid buffer empty, if_ready=1. Release is taken on the first rising edge after rstn goes high. Reset mid-transfer discards everything with no partial update.
- Storage: main register (drives the id_* outputs) and skid register (sk_pc, sk_pcplus4, sk_instr, sk_valid). All id_* outputs come straight from flops; no combinational path from if_* to id_*.
- Handshake definitions: in_fire = if_valid & if_ready; out_fire = id_valid & id_ready.
- State EMPTY (id_valid=0, sk_valid=0):
  - in_fire: load main, go FULL.
  - Otherwise stay EMPTY.
- State FULL (id_valid=1, sk_valid=0):
  - in_fire & out_fire: load main with incoming, stay FULL. Back-to-back throughput is 1/cycle.
  - in_fire & !out_fire: load skid, go SKID.
  - !in_fire & out_fire: go EMPTY.
  - Neither: hold.
- State SKID (id_valid=1, sk_valid=1; if_ready=0, so no in_fire):
  - out_fire: move skid into main, clear sk_valid, go FULL.
  - Otherwise hold.
- Flush: synchronous, highest priority.
  - Clears id_valid and sk_valid and goes to EMPTY.
  - A same-cycle in_fire is dropped.
  - A same-cycle out_fire counts as consumed by decode; the flush does not undo it.
  - Data fields may keep stale values, but id_instr must read NOP_INSTR.
- Ordering: instructions leave in exactly the order accepted. No duplication and no loss except through flush.
- Latency: 1 cycle from in_fire to id_valid when the block was EMPTY or draining.
- Fields are stored verbatim; no arithmetic is performed.
- The block never generates id_valid without a prior in_fire since the last flush or reset.

Optional Feature:
- Macro IFID_PERF_EN.
- Defined: adds three XLEN-bit output ports, each reset to 0 and wrapping modulo 2^XLEN:
  - perf_fetched: increments on in_fire.
  - perf_stall: increments each cycle id_valid & !id_ready.
  - perf_flushed: increments on flush by the number of valid instructions discarded: (id_valid & !out_fire) + sk_valid + (if_valid & if_ready). Range 0..2.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with if_valid=1 -> id_valid=0, id_instr=32'h00000013, if_ready=1 throughout; first capture occurs on the edge after release.
- Streaming: id_ready=1, feed PCs 0x00,0x04,0x08,0x0C on consecutive cycles -> id_pc shows 0x00..0x0C on the following four cycles, id_valid=1 continuously, if_ready never drops.
- Stall into skid: FULL with PC 0x10, id_ready=0, offer PC 0x14 -> accepted, if_ready=0 next cycle, id_pc stays 0x10; raise id_ready -> 0x10 then 0x14 delivered in order, if_ready returns to 1.
- Flush in SKID: main 0x20, skid 0x24, assert flush with if_valid=1, PC 0x28 -> next cycle id_valid=0, id_instr=NOP, if_ready=1; 0x28 never appears; perf_flushed +=2 when IFID_PERF_EN is defined.
- Flush with concurrent consume: FULL 0x30, id_ready=1, flush=1 -> 0x30 counts as consumed, block goes EMPTY, no further output.
- Async reset mid-SKID: drop rstn between clock edges -> outputs reset immediately without waiting for an edge; perf counters read 0.
